// File: rtl/letc_core_pkg.sv
// letc_core_pkg: shared LETC Core types, including the LIMP arbiter state
package letc_core_pkg;
   typedef logic [31:0] paddr_t;
   typedef logic [31:0] word_t;
   typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALFWORD, SIZE_WORD} size_e;
   typedef enum logic {IDLE, GRANT} limp_arb_state_e;
endpackage

// File: rtl/letc_core_rr_picker.sv
// letc_core_rr_picker: combinational round-robin priority encoder, first valid at or above ptr with wrap
module letc_core_rr_picker #(
   parameter int NUM_PORTS = 2,
   parameter int IDX_W     = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] i_valid,
   input  logic [IDX_W-1:0]     i_ptr,
   output logic                 o_any,
   output logic [IDX_W-1:0]     o_idx
);
   int w_best, w_dist;
   always_comb begin
      o_any  = |i_valid;
      o_idx  = '0;
      w_best = NUM_PORTS;
      w_dist = 0;
      for (int j = 0; j < NUM_PORTS; j++) begin
         w_dist = (j + NUM_PORTS - int'(i_ptr)) % NUM_PORTS;
         if (i_valid[j] && w_dist < w_best) begin
            w_best = w_dist;
            o_idx  = IDX_W'(j);
         end
      end
   end
endmodule

// File: rtl/letc_core_limp_arbiter.sv
// letc_core_limp_arbiter: N-to-1 round-robin LIMP arbiter with per-transaction grant lock
module letc_core_limp_arbiter
   import letc_core_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int IDX_W     = $clog2(NUM_PORTS)
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [NUM_PORTS-1:0]   i_req_valid,
   output logic [NUM_PORTS-1:0]   o_req_ready,
   input  logic [NUM_PORTS-1:0]   i_req_wen_nren,
   input  logic [NUM_PORTS-1:0]   i_req_uncacheable,
   input  size_e  [NUM_PORTS-1:0] i_req_size,
   input  paddr_t [NUM_PORTS-1:0] i_req_addr,
   input  word_t  [NUM_PORTS-1:0] i_req_wdata,
   output word_t  [NUM_PORTS-1:0] o_req_rdata,
   output logic                   o_srv_valid,
   output logic                   o_srv_wen_nren,
   output logic                   o_srv_uncacheable,
   output size_e                  o_srv_size,
   output paddr_t                 o_srv_addr,
   output word_t                  o_srv_wdata,
   input  logic                   i_srv_ready,
   input  word_t                  i_srv_rdata,
   output logic                   o_busy,
   output logic [IDX_W-1:0]       o_grant_idx
);
   limp_arb_state_e  r_state;
   logic [IDX_W-1:0] r_grant_idx, r_rr_ptr, w_pick;
   logic             w_any, w_grant, w_lock_valid;

   letc_core_rr_picker #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) u_picker (
      .i_valid(i_req_valid),
      .i_ptr  (r_rr_ptr),
      .o_any  (w_any),
      .o_idx  (w_pick)
   );

   assign w_grant      = r_state == GRANT;
   assign w_lock_valid = i_req_valid[r_grant_idx];

   // A dropped valid while locked releases the grant without advancing the pointer
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_grant_idx <= '0;
         r_rr_ptr    <= '0;
      end else if (r_state == IDLE) begin
         if (w_any) begin
            r_grant_idx <= w_pick;
            r_state     <= GRANT;
         end
      end else if (!w_lock_valid) begin
         r_state <= IDLE;
      end else if (i_srv_ready) begin
         r_state  <= IDLE;
         r_rr_ptr <= (r_grant_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : r_grant_idx + IDX_W'(1);
      end
   end

   assign o_busy            = w_grant;
   assign o_grant_idx       = r_grant_idx;
   assign o_srv_valid       = w_grant & w_lock_valid;
   assign o_srv_wen_nren    = w_grant & i_req_wen_nren[r_grant_idx];
   assign o_srv_uncacheable = w_grant & i_req_uncacheable[r_grant_idx];
   assign o_srv_size        = w_grant ? i_req_size[r_grant_idx] : SIZE_BYTE;
   assign o_srv_addr        = w_grant ? i_req_addr[r_grant_idx] : '0;
   assign o_srv_wdata       = w_grant ? i_req_wdata[r_grant_idx] : '0;

   always_comb begin
      o_req_ready              = '0;
      o_req_rdata              = '0;
      o_req_ready[r_grant_idx] = w_grant & i_srv_ready;
      o_req_rdata[r_grant_idx] = w_grant ? i_srv_rdata : '0;
   end

`ifdef SIMULATION
   always_ff @(posedge i_clk) begin
      if (i_rst_n) begin
         assert ($onehot0(o_req_ready)) else $error("o_req_ready not one-hot-or-zero: %b", o_req_ready);
         assert (!(w_grant && !w_lock_valid)) else $warning("LIMP protocol violation: port %0d dropped valid before ready", r_grant_idx);
      end
   end
   assert property (@(posedge i_clk) disable iff (!i_rst_n)
      (o_srv_valid && !i_srv_ready) |=> (!o_srv_valid ||
      $stable({o_srv_wen_nren, o_srv_uncacheable, o_srv_size, o_srv_addr, o_srv_wdata})))
      else $error("LIMP request fields changed while waiting for ready");
`endif
endmodule

// File: tb/tb_letc_core_limp_arbiter.sv
// tb_letc_core_limp_arbiter: directed scenarios plus random traffic against a behavioural arbiter model
module tb_letc_core_limp_arbiter;
   import letc_core_pkg::*;
   localparam int N     = 5;
   localparam int IDX_W = $clog2(N);

   logic clk = 0, rst_n = 0;
   logic [N-1:0] req_valid = '0, req_wen = '0, req_unc = '0, o_req_ready, hs = '0;
   size_e  [N-1:0] req_size = '0;
   paddr_t [N-1:0] req_addr = '0;
   word_t  [N-1:0] req_wdata = '0, o_req_rdata;
   logic srv_ready = 0, o_srv_valid, o_srv_wen_nren, o_srv_uncacheable, o_busy;
   word_t srv_rdata = '0, o_srv_wdata;
   size_e o_srv_size;
   paddr_t o_srv_addr;
   logic [IDX_W-1:0] o_grant_idx;

   int n_pass = 0, n_total = 0, cyc_n = 0;
   int m_owner = -1, m_ptr = 0, m_idx = 0;
   int g_port[$], g_cyc[$];
   logic e_busy;
   logic [N-1:0] e_rdy;
   word_t [N-1:0] e_rd;
   logic [68:0] e_srv;

   letc_core_limp_arbiter #(.NUM_PORTS(N)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_valid(req_valid), .o_req_ready(o_req_ready),
      .i_req_wen_nren(req_wen), .i_req_uncacheable(req_unc),
      .i_req_size(req_size), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
      .o_req_rdata(o_req_rdata),
      .o_srv_valid(o_srv_valid), .o_srv_wen_nren(o_srv_wen_nren),
      .o_srv_uncacheable(o_srv_uncacheable), .o_srv_size(o_srv_size),
      .o_srv_addr(o_srv_addr), .o_srv_wdata(o_srv_wdata),
      .i_srv_ready(srv_ready), .i_srv_rdata(srv_rdata),
      .o_busy(o_busy), .o_grant_idx(o_grant_idx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h want %0h", name, act, exp);
      else n_pass++;
   endtask

   // Round-robin reference: first valid port at or after the pointer, wrapping modulo N
   function automatic int first_from(input int ptr);
      for (int k = 0; k < N; k++) if (req_valid[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_owner <= -1; m_ptr <= 0; m_idx <= 0;
      end else if (m_owner < 0) begin
         if (first_from(m_ptr) >= 0) begin
            m_owner <= first_from(m_ptr); m_idx <= first_from(m_ptr);
         end
      end else if (!req_valid[m_owner]) m_owner <= -1;
      else if (srv_ready) begin
         m_ptr <= (m_owner + 1) % N; m_owner <= -1;
      end
   end

   always @(negedge clk) begin
      e_busy = m_owner >= 0;
      e_rdy = '0; e_rd = '0; e_srv = '0;
      if (m_owner >= 0) begin
         e_rdy[m_owner] = srv_ready;
         e_rd[m_owner]  = srv_rdata;
         e_srv = {req_valid[m_owner], req_wen[m_owner], req_unc[m_owner], req_size[m_owner], req_addr[m_owner], req_wdata[m_owner]};
      end
      chk("srv_bus", {o_srv_valid, o_srv_wen_nren, o_srv_uncacheable, o_srv_size, o_srv_addr, o_srv_wdata}, e_srv);
      chk("req_ready", o_req_ready, e_rdy);
      chk("req_rdata", o_req_rdata, e_rd);
      chk("busy_idx", {o_busy, o_grant_idx}, {e_busy, IDX_W'(m_idx)});
      hs = req_valid & o_req_ready;
      if (o_srv_valid && srv_ready) begin
         g_port.push_back(int'(o_grant_idx));
         g_cyc.push_back(cyc_n);
      end
   end

   task automatic tick();
      @(posedge clk); #1;
      for (int p = 0; p < N; p++) if (hs[p]) req_valid[p] = 0;
   endtask

   task automatic raise(input int p, input logic wen, input paddr_t a, input word_t d);
      req_valid[p] = 1; req_wen[p] = wen; req_unc[p] = 1'($urandom);
      req_size[p] = size_e'($urandom_range(0, 2)); req_addr[p] = a; req_wdata[p] = d;
   endtask

   task automatic raise_rand(input int p);
      raise(p, 1'($urandom), $urandom, $urandom);
   endtask

   task automatic drain();
      srv_ready = 1;
      for (int k = 0; k < 80 && |req_valid; k++) tick();
      chk("drain", |req_valid, 1'b0);
   endtask

   task automatic expect_grant(input string name, input int p);
      @(negedge clk);
      chk(name, {o_busy, o_grant_idx}, {1'b1, IDX_W'(p)});
   endtask

   initial begin
      paddr_t a0;
      repeat (2) tick();
      rst_n = 1;
      @(negedge clk);
      chk("rst_busy_idx", {o_busy, o_grant_idx}, '0);
      chk("rst_ready", o_req_ready, '0);
      chk("rst_srv_valid", o_srv_valid, 1'b0);

      // single read on port 1, zero-wait servicer
      tick(); raise(1, 0, 32'h0000_1000, '0); srv_ready = 1; srv_rdata = 32'hDEADBEEF;
      @(negedge clk); chk("t1_arb_cycle_idle", o_srv_valid, 1'b0);
      tick(); @(negedge clk);
      chk("t1_srv_valid", o_srv_valid, 1'b1);
      chk("t1_srv_addr", o_srv_addr, 32'h0000_1000);
      chk("t1_ready", o_req_ready, 5'b00010);
      chk("t1_rdata", o_req_rdata[1], 32'hDEADBEEF);
      tick(); raise_rand(0); raise_rand(2);
      @(negedge clk); chk("t1_back_idle", o_busy, 1'b0);
      tick(); expect_grant("t1_next_after_1", 2);
      tick(); tick(); expect_grant("t1_then_0", 0);
      tick(); drain();

      // all ports continuously valid
      rst_n = 0; tick(); rst_n = 1;
      g_port.delete(); g_cyc.delete();
      for (int p = 0; p < N; p++) raise_rand(p);
      srv_ready = 1;
      repeat (13) begin
         tick();
         for (int p = 0; p < N; p++) if (!req_valid[p]) raise_rand(p);
      end
      chk("rr_count", g_port.size() >= 6, 1'b1);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("rr_order%0d", i), (i < g_port.size()) ? g_port[i] : -1, i % N);
         if (i > 0) chk($sformatf("rr_gap%0d", i), (i < g_cyc.size()) ? g_cyc[i] - g_cyc[i-1] : -1, 2);
      end
      drain();

      // port 0 write stalled 5 cycles, port 1 arrives mid-stall
      srv_ready = 0; a0 = $urandom; raise(0, 1, a0, 32'h1234_5678);
      tick();
      for (int i = 0; i < 6; i++) begin
         if (i == 2) raise_rand(1);
         if (i == 5) srv_ready = 1;
         @(negedge clk);
         chk($sformatf("stall_wdata%0d", i), o_srv_wdata, 32'h1234_5678);
         chk($sformatf("stall_addr%0d", i), o_srv_addr, a0);
         chk($sformatf("stall_ready%0d", i), o_req_ready, (i == 5) ? 5'b00001 : 5'b00000);
         tick();
      end
      tick(); expect_grant("stall_next_port1", 1);
      tick();

      // port 4 served while 0 and 3 wait: pointer wraps to 0
      raise_rand(3); tick(); expect_grant("wrap_setup3", 3);
      tick(); raise_rand(4); tick(); raise_rand(0); raise_rand(3);
      expect_grant("wrap_port4", 4);
      tick(); tick(); expect_grant("wrap_first0", 0);
      tick(); tick(); expect_grant("wrap_second3", 3);
      tick(); drain();

      // asynchronous reset while a request is presented to the servicer
      tick(); srv_ready = 0; raise_rand(2);
      tick(); @(negedge clk); chk("pre_rst_srv_valid", o_srv_valid, 1'b1);
      #2 rst_n = 0;
      #1;
      chk("async_rst_srv", {o_srv_valid, o_srv_addr, o_srv_wdata}, '0);
      chk("async_rst_busy_idx", {o_busy, o_grant_idx}, '0);
      chk("async_rst_ready", o_req_ready, '0);
      tick(); req_valid[2] = 0; raise_rand(1); raise_rand(3); srv_ready = 1;
      tick(); rst_n = 1;
      tick(); expect_grant("post_rst_scan0", 1);
      tick(); drain();

      // locked port drops valid before ready
      rst_n = 0; tick(); rst_n = 1; srv_ready = 0; raise_rand(3);
      tick(); expect_grant("viol_grant", 3);
      tick(); req_valid[3] = 0;
      @(negedge clk); chk("viol_drop", {o_busy, o_srv_valid}, 2'b10);
      tick(); @(negedge clk); chk("viol_idle", o_busy, 1'b0);
      tick(); raise_rand(1); raise_rand(4); srv_ready = 1;
      tick(); expect_grant("viol_ptr_kept", 1);
      tick(); drain();

      // random traffic, model comparison runs every cycle
      for (int c = 0; c < 3000; c++) begin
         tick();
         srv_ready = $urandom_range(0, 2) != 0;
         srv_rdata = $urandom;
         for (int p = 0; p < N; p++) if (!req_valid[p] && $urandom_range(0, 2) == 0) raise_rand(p);
      end
      tick(); drain();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule
